// File: rtl/seq_stage_controller.sv
// Multi-cycle Y86-64 SEQ sequencer: steps F/D/E/M/W/P one phase per cycle, owns the PC,
// tracks processor status and the retired-instruction count. All outputs are registered.
module seq_stage_controller #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          CNT_W       = 32,
  parameter int          MEM_TIMEOUT = 15
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             step_mode_i,
  input  logic [3:0]       icode_i,
  input  logic             cnd_i,
  input  logic [63:0]      valc_i,
  input  logic [63:0]      valp_i,
  input  logic [63:0]      valm_i,
  input  logic             instr_valid_i,
  input  logic             imem_error_i,
  input  logic             mem_ready_i,
  input  logic             dmem_error_i,
  output logic [63:0]      pc_o,
  output logic [5:0]       stage_en_o,
  output logic [2:0]       stat_o,
  output logic             busy_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] instr_count_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  // Last wait-count value before the counter would reach MEM_TIMEOUT.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_HALTED
  } state_e;

  state_e            state_q, state_d;
  logic [63:0]       pc_q, pc_d;
  logic [2:0]        stat_q, stat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [5:0]        stage_en_q;
  logic              busy_q;
  logic              halted_q;
  logic [63:0]       next_pc;

  function automatic logic [5:0] stage_of(input state_e s);
    case (s)
      S_FETCH:     return 6'b000001;
      S_DECODE:    return 6'b000010;
      S_EXECUTE:   return 6'b000100;
      S_MEMORY:    return 6'b001000;
      S_WRITEBACK: return 6'b010000;
      S_PCUPD:     return 6'b100000;
      default:     return 6'b000000;
    endcase
  endfunction

  always_comb begin
    next_pc = valp_i;
    if (icode_i == 4'h7 && cnd_i) begin
      next_pc = valc_i;
    end else if (icode_i == 4'h8) begin
      next_pc = valc_i;
    end else if (icode_i == 4'h9) begin
      next_pc = valm_i;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stat_d  = stat_q;
    cnt_d   = cnt_q;
    wait_d  = '0;  // the wait counter only survives while staying in MEMORY
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_error_i) begin
          stat_d  = STAT_ADR;
          state_d = S_HALTED;
        end else if (!instr_valid_i) begin
          stat_d  = STAT_INS;
          state_d = S_HALTED;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: state_d = S_MEMORY;
      S_MEMORY: begin
        // A ready arriving on the final allowed cycle takes precedence over the timeout.
        if (mem_ready_i) begin
          if (dmem_error_i) begin
            stat_d  = STAT_ADR;
            state_d = S_HALTED;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (wait_q == WAIT_LAST) begin
          stat_d  = STAT_ADR;
          state_d = S_HALTED;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD: begin
        pc_d  = next_pc;
        cnt_d = cnt_q + CNT_W'(1);
        if (icode_i == 4'h0) begin
          stat_d  = STAT_HLT;
          state_d = S_HALTED;
        end else if (step_mode_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Phase outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      stat_q     <= STAT_AOK;
      cnt_q      <= '0;
      wait_q     <= '0;
      stage_en_q <= 6'b000000;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      stat_q     <= stat_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      stage_en_q <= stage_of(state_d);
      busy_q     <= (stage_of(state_d) != 6'b000000);
      halted_q   <= (state_d == S_HALTED);
    end
  end

  assign pc_o          = pc_q;
  assign stage_en_o    = stage_en_q;
  assign stat_o        = stat_q;
  assign busy_o        = busy_q;
  assign halted_o      = halted_q;
  assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_seq_stage_controller.sv
// Scoreboarded bench for seq_stage_controller: driver issues instructions and queues the
// architectural outcome; a monitor pops and compares at each retire or halt.
module tb_seq_stage_controller;

  localparam logic [63:0] RESET_PC    = 64'h100;
  localparam int          CNT_W       = 6;
  localparam int          MEM_TIMEOUT = 15;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             step_mode;
  logic [3:0]       icode;
  logic             cnd;
  logic [63:0]      valc, valp, valm;
  logic             instr_valid;
  logic             imem_error;
  logic             mem_ready;
  logic             dmem_error;
  logic [63:0]      pc;
  logic [5:0]       stage_en;
  logic [2:0]       stat;
  logic             busy;
  logic             halted;
  logic [CNT_W-1:0] instr_count;

  seq_stage_controller #(
    .RESET_PC(RESET_PC), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .step_mode_i(step_mode),
    .icode_i(icode), .cnd_i(cnd), .valc_i(valc), .valp_i(valp), .valm_i(valm),
    .instr_valid_i(instr_valid), .imem_error_i(imem_error),
    .mem_ready_i(mem_ready), .dmem_error_i(dmem_error),
    .pc_o(pc), .stage_en_o(stage_en), .stat_o(stat), .busy_o(busy),
    .halted_o(halted), .instr_count_o(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    int          cnt;
    int          stat;
    int          halted;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [63:0] m_pc;
  int          m_cnt;
  bit          mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic note_timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // Monitor: an instruction's outcome becomes visible the cycle after PCUPD, or when halted rises.
  logic [5:0] prev_stage;
  logic       prev_halted;
  int         busy_cyc;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || !mon_en) begin
      prev_stage  = 6'b0;
      prev_halted = 1'b0;
      busy_cyc    = 0;
    end else begin
      if (prev_stage == 6'b100000 || (halted && !prev_halted)) begin
        if (sb.size() == 0) begin
          note_timeout("unexpected_retire_no_expectation");
        end else begin
          e = sb.pop_front();
          chk("retire_pc", pc, e.pc);
          chk("retire_count", 64'(instr_count), 64'(e.cnt));
          chk("retire_stat", 64'(stat), 64'(e.stat));
          chk("retire_halted", 64'(halted), 64'(e.halted));
          chk("retire_latency", 64'(busy_cyc), 64'(e.lat));
        end
      end
      if (stage_en == 6'b000001) busy_cyc = 1;
      else if (busy) busy_cyc++;
      prev_stage  = stage_en;
      prev_halted = halted;
    end
  end

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n = 1'b0;
    start = 1'b0; step_mode = 1'b0; icode = 4'h1; cnd = 1'b0;
    valc = '0; valp = '0; valm = '0;
    instr_valid = 1'b1; imem_error = 1'b0; mem_ready = 1'b0; dmem_error = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    m_pc  = RESET_PC;
    m_cnt = 0;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic wait_fetch(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (stage_en == 6'b000001) begin
        start = 1'b0;
        ok = 1'b1;
        return;
      end
      start = (stage_en == 6'b000000) && !halted;
    end
    start = 1'b0;
    note_timeout("wait_fetch");
  endtask

  // nwait >= MEM_TIMEOUT means mem_ready never arrives.
  task automatic issue(input logic [3:0] ic, input logic c, input logic [63:0] vc,
                       input logic [63:0] vp, input logic [63:0] vm, input logic iv,
                       input logic ie, input int nwait, input logic derr, input logic sm);
    exp_t e;
    bit   ok;
    int   k;
    wait_fetch(ok);
    if (!ok) return;
    icode = ic; cnd = c; valc = vc; valp = vp; valm = vm;
    instr_valid = iv; imem_error = ie; step_mode = sm;
    e.stat = 1; e.halted = 0;
    if (ie) begin
      e.stat = 3; e.halted = 1; e.lat = 1;
    end else if (!iv) begin
      e.stat = 4; e.halted = 1; e.lat = 1;
    end else if (nwait >= MEM_TIMEOUT) begin
      e.stat = 3; e.halted = 1; e.lat = 3 + MEM_TIMEOUT;
    end else if (derr) begin
      e.stat = 3; e.halted = 1; e.lat = 4 + nwait;
    end else begin
      case (ic)
        4'h7:    m_pc = c ? vc : vp;
        4'h8:    m_pc = vc;
        4'h9:    m_pc = vm;
        default: m_pc = vp;
      endcase
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
      e.lat = 6 + nwait;
      if (ic == 4'h0) begin
        e.stat = 2; e.halted = 1;
      end
    end
    e.pc  = m_pc;
    e.cnt = m_cnt;
    sb.push_back(e);
    if (ie || !iv) return;
    for (int t = 0; stage_en != 6'b001000; t++) begin
      if (t > 20) begin
        note_timeout("wait_memory");
        return;
      end
      @(negedge clk);
    end
    k = 0;
    forever begin
      mem_ready  = (k >= nwait) && (nwait < MEM_TIMEOUT);
      dmem_error = mem_ready ? derr : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (stage_en != 6'b001000) break;
      k++;
      if (k > 100) begin
        note_timeout("memory_stuck");
        break;
      end
    end
    mem_ready = 1'b0;
    dmem_error = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge clk);
    if (sb.size() != 0) note_timeout("scoreboard_drain");
    @(negedge clk);
  endtask

  task automatic issue_rand_good();
    issue(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
          {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
          1'b1, 1'b0, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 14)) : 0,
          1'b0, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_pc", pc, RESET_PC);
    chk("reset_stage_en", 64'(stage_en), 64'd0);
    chk("reset_stat", 64'(stat), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_halted", 64'(halted), 64'd0);
    chk("reset_count", 64'(instr_count), 64'd0);
    do_reset();

    // Directed sequence from the plan, ending in halt.
    issue(4'h6, 1'b0, 64'h0,  64'h2,  64'h0,   1'b1, 1'b0, 0, 1'b0, 1'b0);
    issue(4'h7, 1'b1, 64'h40, 64'h7,  64'h0,   1'b1, 1'b0, 0, 1'b0, 1'b0);
    issue(4'h7, 1'b0, 64'h40, 64'hA,  64'h0,   1'b1, 1'b0, 0, 1'b0, 1'b0);
    issue(4'h9, 1'b0, 64'h55, 64'hB,  64'h100, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    issue(4'h8, 1'b1, 64'h80, 64'hC,  64'h0,   1'b1, 1'b0, 3, 1'b0, 1'b0);
    issue(4'h3, 1'b1, 64'h99, 64'hD0, 64'h0,   1'b1, 1'b0, 0, 1'b0, 1'b1);
    issue(4'h6, 1'b0, 64'h0,  64'hE0, 64'h0,   1'b1, 1'b0, 14, 1'b0, 1'b1);
    issue(4'h0, 1'b0, 64'h0,  64'h1,  64'h0,   1'b1, 1'b0, 0, 1'b0, 1'b0);
    drain();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("sticky_halted", 64'(halted), 64'd1);
    chk("sticky_stage_en", 64'(stage_en), 64'd0);
    chk("sticky_busy", 64'(busy), 64'd0);
    chk("sticky_pc", pc, 64'h1);
    chk("sticky_stat", 64'(stat), 64'd2);

    // Long random run; count wraps modulo 2^CNT_W.
    do_reset();
    for (int i = 0; i < 150; i++) issue_rand_good();
    issue(4'h0, 1'b0, 64'h0, {$urandom, $urandom}, 64'h0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    drain();

    // Each fault kind after a few good instructions.
    for (int kind = 0; kind < 4; kind++) begin
      do_reset();
      for (int i = 0; i < 3; i++) issue_rand_good();
      case (kind)
        0: issue(4'h6, 1'b0, 64'h1, 64'h2, 64'h3, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        1: issue(4'h6, 1'b0, 64'h1, 64'h2, 64'h3, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        2: issue(4'h9, 1'b0, 64'h1, 64'h2, 64'h3, 1'b1, 1'b0,
                 int'($urandom_range(0, 14)), 1'b1, 1'b0);
        default: issue(4'h8, 1'b0, 64'h1, 64'h2, 64'h3, 1'b1, 1'b0, MEM_TIMEOUT, 1'b0, 1'b0);
      endcase
      drain();
    end

    // Asynchronous reset mid-EXECUTE, after some state has accumulated.
    do_reset();
    issue(4'h8, 1'b0, 64'h777, 64'h5, 64'h0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    drain();
    mon_en = 1'b0;
    icode = 4'h6; valp = 64'h999; instr_valid = 1'b1; imem_error = 1'b0;
    start = 1'b1;
    begin : wait_exec
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        start = 1'b0;
        if (stage_en == 6'b000100) disable wait_exec;
      end
      note_timeout("wait_execute");
    end
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_pc", pc, RESET_PC);
    chk("async_reset_stage_en", 64'(stage_en), 64'd0);
    chk("async_reset_busy", 64'(busy), 64'd0);
    chk("async_reset_count", 64'(instr_count), 64'd0);
    chk("async_reset_stat", 64'(stat), 64'd1);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
